multicycle_ctrl: RTL

Main control unit for the multicycle CPU datapath. It sequences the shared ALU, its operand muxes (including the 4-input ALUSrcB mux), the memory, the instruction register, the register file and the PC across fetch, decode, execute, memory and write-back cycles. It also supports wait-stated memory and raises overflow and invalid-opcode exceptions. The block is a registered Moore FSM with one Mealy term, the branch PC write.

---
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM for a multicycle CPU datapath. It sequences
//            fetch / decode / execute / memory / write-back, and supports
//            wait-stated memory plus overflow and invalid-opcode exceptions.
//            Outputs are Moore, except that the branch PC write follows zero.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_WAIT = 0            // extra wait cycles per memory access (0..15)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       overflow,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       pc_write,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       EPCWrite,
  output logic       cause,
  output logic [3:0] state_out
);

  // State encodings are visible on state_out, so they are fixed values.
  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_EXEC_R    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_EXEC_I    = 4'd9;
  localparam logic [3:0] S_I_WB      = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_EXCEPT    = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cause_q, cause_d;
  logic       mem_done;

  // A memory state has run its MEM_WAIT + 1 cycles when the counter hits the limit.
  assign mem_done = (cnt_q == WAIT_LAST);

  // Next-state, wait-counter and cause logic. The counter is zero whenever a
  // memory state is entered because every non-holding path loads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    cause_d = cause_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_done) state_d = S_DECODE;
        else          cnt_d   = cnt_q + 4'd1;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_EXEC_I;
          default: begin
            state_d = S_EXCEPT;
            cause_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_done) state_d = S_MEM_WB;
        else          cnt_d   = cnt_q + 4'd1;
      end
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_done) state_d = S_FETCH;
        else          cnt_d   = cnt_q + 4'd1;
      end
      S_EXEC_R, S_EXEC_I: begin
        if (overflow) begin
          state_d = S_EXCEPT;
          cause_d = 1'b0;
        end else begin
          state_d = (state_q == S_EXEC_R) ? S_R_WB : S_I_WB;
        end
      end
      S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_EXCEPT: state_d = S_FETCH;
      default: state_d = S_RESET;
    endcase
  end

  // State registers; asynchronous reset drops all enables immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      cnt_q   <= 4'd0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Datapath controls decoded from the current state; pc_write in BRANCH also follows zero.
  always_comb begin
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    pc_write = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    EPCWrite = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_done) begin
          IRWrite  = 1'b1;
          ALUSrcB  = 2'b01;
          pc_write = 1'b1;
        end
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_I_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        pc_write = (opcode == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        pc_write = 1'b1;
      end
      S_EXCEPT: begin
        // ALU computes PC - 4, the address of the faulting instruction.
        ALUSrcB  = 2'b01;
        ALUOp    = 2'b01;
        EPCWrite = 1'b1;
        PCSource = 2'b11;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign cause     = cause_q;
  assign state_out = state_q;

endmodule
`default_nettype wire
